// File: rtl/cic3_row_readout_ctrl_pkg.sv
// Shared constants and types for the CIC3 row readout sequencer.
package cic3_row_pkg;
  localparam int NUM_FILTERS = 24;
  localparam int WORD_W      = 25;
  localparam int CH_ID_W     = 5;

  typedef enum logic [0:0] {IDLE, SEND} rd_state_t;
  typedef logic [WORD_W-1:0] cic_word_t;
endpackage

// File: rtl/cic3_row_readout_ctrl_if.sv
// Word-stream output bus: one filter word per transfer, valid/ready handshake.
interface cic3_row_readout_ctrl_if;
  import cic3_row_pkg::*;

  cic_word_t          out_data;
  logic [CH_ID_W-1:0] out_ch;
  logic               out_valid;
  logic               out_ready;
  logic               out_last;

  modport master (output out_data, output out_ch, output out_valid, output out_last,
                  input out_ready);
  modport slave  (input out_data, input out_ch, input out_valid, input out_last,
                  output out_ready);
endinterface

// File: rtl/cic3_row_readout_ctrl_next_ch.sv
// Finds the next enabled channel above ptr (or the lowest one in first mode),
// and reports whether none or exactly one candidate remains.
module cic3_next_ch
  import cic3_row_pkg::*;
(
  input  logic [NUM_FILTERS-1:0] mask,
  input  logic [CH_ID_W-1:0]     ptr,
  input  logic                   first,
  output logic [CH_ID_W-1:0]     next_ch,
  output logic                   none_left,
  output logic                   one_left
);
  logic [NUM_FILTERS-1:0] cand;

  generate
    for (genvar gi = 0; gi < NUM_FILTERS; gi++) begin : g_cand
      assign cand[gi] = mask[gi] & (first | (CH_ID_W'(gi) > ptr));
    end
  endgenerate

  // Descending scan so the lowest candidate is the final assignment.
  always_comb begin
    next_ch = '0;
    for (int i = NUM_FILTERS - 1; i >= 0; i--) begin
      if (cand[i]) next_ch = CH_ID_W'(i);
    end
  end

  assign none_left = ~|cand;
  assign one_left  = $onehot(cand);
endmodule

// File: rtl/cic3_row_readout_ctrl.sv
// Snapshots the CIC3 row on each decimation strobe and streams the enabled
// channels over a valid/ready bus, counting frames and flagging dropped strobes.
module cic3_row_readout_ctrl
  import cic3_row_pkg::*;
#(
  parameter int FRAME_CNT_W = 16
) (
  input  logic                          clk,
  input  logic                          reset,
  input  logic [NUM_FILTERS*WORD_W-1:0] row_data,
  input  logic                          sample_strobe,
  input  logic [NUM_FILTERS-1:0]        ch_enable,
  cic3_row_readout_ctrl_if.master       bus,
  output logic                          busy,
  output logic [FRAME_CNT_W-1:0]        frame_cnt,
  output logic                          overrun,
  input  logic                          overrun_clr
);
  rd_state_t              state_reg;
  cic_word_t              snap_reg [NUM_FILTERS];
  cic_word_t              row_word [NUM_FILTERS];
  logic [NUM_FILTERS-1:0] mask_reg;
  cic_word_t              out_data_reg;
  logic [CH_ID_W-1:0]     out_ch_reg;
  logic                   out_valid_reg, out_last_reg, busy_reg, overrun_reg;
  logic [FRAME_CNT_W-1:0] frame_cnt_reg;

  logic [CH_ID_W-1:0] first_ch, adv_ch;
  logic               first_none, first_one, adv_none, adv_one;
  logic               xfer, final_xfer, accept, drop;

  generate
    for (genvar gi = 0; gi < NUM_FILTERS; gi++) begin : g_row
      assign row_word[gi] = row_data[gi*WORD_W +: WORD_W];
    end
  endgenerate

  cic3_next_ch first_sel (
    .mask(ch_enable), .ptr('0), .first(1'b1),
    .next_ch(first_ch), .none_left(first_none), .one_left(first_one)
  );

  // out_ch doubles as the channel pointer while a frame drains.
  cic3_next_ch adv_sel (
    .mask(mask_reg), .ptr(out_ch_reg), .first(1'b0),
    .next_ch(adv_ch), .none_left(adv_none), .one_left(adv_one)
  );

  assign xfer       = out_valid_reg & bus.out_ready;
  assign final_xfer = xfer & adv_none;
  assign accept     = sample_strobe & ((state_reg == IDLE) | final_xfer);
  assign drop       = sample_strobe & (state_reg == SEND) & ~final_xfer;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_reg     <= IDLE;
      mask_reg      <= '0;
      out_data_reg  <= '0;
      out_ch_reg    <= '0;
      out_valid_reg <= 1'b0;
      out_last_reg  <= 1'b0;
      busy_reg      <= 1'b0;
      overrun_reg   <= 1'b0;
      frame_cnt_reg <= '0;
      for (int i = 0; i < NUM_FILTERS; i++) snap_reg[i] <= '0;
    end else begin
      if (drop)             overrun_reg <= 1'b1;
      else if (overrun_clr) overrun_reg <= 1'b0;

      if (accept) begin
        mask_reg <= ch_enable;
        for (int i = 0; i < NUM_FILTERS; i++) snap_reg[i] <= row_word[i];
      end

      if (accept && !first_none) begin
        state_reg     <= SEND;
        out_valid_reg <= 1'b1;
        busy_reg      <= 1'b1;
        out_ch_reg    <= first_ch;
        out_data_reg  <= row_word[first_ch];
        out_last_reg  <= first_one;
      end else if (xfer && !adv_none) begin
        out_ch_reg    <= adv_ch;
        out_data_reg  <= snap_reg[adv_ch];
        out_last_reg  <= adv_one;
      end else if (final_xfer || accept) begin
        state_reg     <= IDLE;
        out_valid_reg <= 1'b0;
        busy_reg      <= 1'b0;
        out_last_reg  <= 1'b0;
      end

      // A drained frame and an empty-mask strobe can both complete in one cycle.
      frame_cnt_reg <= frame_cnt_reg + FRAME_CNT_W'(final_xfer)
                                     + FRAME_CNT_W'(accept && first_none);
    end
  end

  assign bus.out_data  = out_data_reg;
  assign bus.out_ch    = out_ch_reg;
  assign bus.out_valid = out_valid_reg;
  assign bus.out_last  = out_last_reg;
  assign busy          = busy_reg;
  assign frame_cnt     = frame_cnt_reg;
  assign overrun       = overrun_reg;
endmodule

// File: tb/tb_cic3_row_readout_ctrl.sv
// Directed bench for the CIC3 row readout sequencer; outputs sampled on negedge.
module tb_cic3_row_readout_ctrl;
  import cic3_row_pkg::*;

  logic                          clk = 1'b0;
  logic                          reset;
  logic [NUM_FILTERS*WORD_W-1:0] row_data;
  logic                          sample_strobe;
  logic [NUM_FILTERS-1:0]        ch_enable;
  logic                          busy;
  logic [15:0]                   frame_cnt;
  logic                          overrun;
  logic                          overrun_clr;

  int          n_checks = 0;
  int          n_fails  = 0;
  logic [15:0] exp_frames = '0;

  cic3_row_readout_ctrl_if bus ();

  cic3_row_readout_ctrl #(.FRAME_CNT_W(16)) dut (
    .clk(clk), .reset(reset), .row_data(row_data), .sample_strobe(sample_strobe),
    .ch_enable(ch_enable), .bus(bus), .busy(busy), .frame_cnt(frame_cnt),
    .overrun(overrun), .overrun_clr(overrun_clr)
  );

  always #5 clk = ~clk;

  task automatic tick();
    @(negedge clk);
  endtask

  task automatic set_row_inc();
    for (int k = 0; k < NUM_FILTERS; k++) row_data[k*WORD_W +: WORD_W] = WORD_W'(k + 1);
  endtask

  task automatic set_row_const(input logic [WORD_W-1:0] v);
    for (int k = 0; k < NUM_FILTERS; k++) row_data[k*WORD_W +: WORD_W] = v;
  endtask

  task automatic test_reset();
    reset = 1'b1; sample_strobe = 1'b0; ch_enable = '0; overrun_clr = 1'b0;
    bus.out_ready = 1'b0; set_row_inc();
    tick();
    n_checks++;
    if ({bus.out_valid, bus.out_last, busy, overrun} !== 4'b0000) begin
      n_fails++; $display("FAIL reset_flags: got %b want 0000", {bus.out_valid, bus.out_last, busy, overrun});
    end
    n_checks++;
    if (bus.out_data !== '0 || bus.out_ch !== '0 || frame_cnt !== 16'd0) begin
      n_fails++; $display("FAIL reset_values: data=%h ch=%0d frame=%0d want 0", bus.out_data, bus.out_ch, frame_cnt);
    end
    reset = 1'b0;
    tick();
    $display("reset released");
  endtask

  task automatic test_all_channels();
    bus.out_ready = 1'b1; set_row_inc(); ch_enable = '1; sample_strobe = 1'b1;
    tick();
    sample_strobe = 1'b0;
    n_checks++;
    if (bus.out_valid !== 1'b1 || busy !== 1'b1) begin
      n_fails++; $display("FAIL valid_latency: valid=%b busy=%b want 1 1", bus.out_valid, busy);
    end
    for (int i = 0; i < NUM_FILTERS; i++) begin
      $display("word ch=%0d data=%h last=%b", bus.out_ch, bus.out_data, bus.out_last);
      n_checks++;
      if (bus.out_valid !== 1'b1 || bus.out_ch !== CH_ID_W'(i) || bus.out_data !== WORD_W'(i + 1)
          || bus.out_last !== (i == NUM_FILTERS - 1)) begin
        n_fails++;
        $display("FAIL all_word%0d: valid=%b ch=%0d data=%h last=%b want 1 %0d %h %b",
                 i, bus.out_valid, bus.out_ch, bus.out_data, bus.out_last, i, i + 1, i == NUM_FILTERS - 1);
      end
      tick();
    end
    exp_frames++;
    n_checks++;
    if (bus.out_valid !== 1'b0 || busy !== 1'b0 || frame_cnt !== exp_frames) begin
      n_fails++; $display("FAIL all_end: valid=%b busy=%b frame=%0d want 0 0 %0d", bus.out_valid, busy, frame_cnt, exp_frames);
    end
  endtask

  task automatic test_sparse_ready_toggle();
    for (int k = 0; k < NUM_FILTERS; k++) row_data[k*WORD_W +: WORD_W] = 25'h0A0000 | WORD_W'(k);
    ch_enable = 24'h800001; bus.out_ready = 1'b0; sample_strobe = 1'b1;
    tick();
    sample_strobe = 1'b0;
    for (int c = 0; c < 4; c++) begin
      logic [CH_ID_W-1:0] ech;
      ech = (c < 2) ? 5'd0 : 5'd23;
      $display("word ch=%0d data=%h last=%b ready=%b", bus.out_ch, bus.out_data, bus.out_last, bus.out_ready);
      n_checks++;
      if (bus.out_valid !== 1'b1 || bus.out_ch !== ech || bus.out_data !== (25'h0A0000 | WORD_W'(ech))
          || bus.out_last !== (c >= 2)) begin
        n_fails++;
        $display("FAIL sparse_cycle%0d: valid=%b ch=%0d data=%h last=%b want 1 %0d %h %b",
                 c, bus.out_valid, bus.out_ch, bus.out_data, bus.out_last, ech, 25'h0A0000 | WORD_W'(ech), c >= 2);
      end
      bus.out_ready = (c == 1 || c == 3);
      tick();
    end
    bus.out_ready = 1'b1;
    exp_frames++;
    n_checks++;
    if (bus.out_valid !== 1'b0 || frame_cnt !== exp_frames) begin
      n_fails++; $display("FAIL sparse_end: valid=%b frame=%0d want 0 %0d", bus.out_valid, frame_cnt, exp_frames);
    end
  endtask

  task automatic test_empty_mask();
    ch_enable = '0; sample_strobe = 1'b1;
    tick();
    sample_strobe = 1'b0;
    exp_frames++;
    $display("empty strobe frame=%0d", frame_cnt);
    n_checks++;
    if (bus.out_valid !== 1'b0 || busy !== 1'b0 || frame_cnt !== exp_frames) begin
      n_fails++; $display("FAIL empty_mask: valid=%b busy=%b frame=%0d want 0 0 %0d", bus.out_valid, busy, frame_cnt, exp_frames);
    end
  endtask

  task automatic test_overrun();
    set_row_inc(); ch_enable = '1; bus.out_ready = 1'b1; sample_strobe = 1'b1;
    tick();
    sample_strobe = 1'b0;
    for (int i = 0; i < NUM_FILTERS; i++) begin
      n_checks++;
      if (bus.out_valid !== 1'b1 || bus.out_ch !== CH_ID_W'(i) || bus.out_data !== WORD_W'(i + 1)) begin
        n_fails++;
        $display("FAIL ovr_word%0d: valid=%b ch=%0d data=%h want 1 %0d %h", i, bus.out_valid, bus.out_ch, bus.out_data, i, i + 1);
      end
      if (i == 4) begin
        sample_strobe = 1'b1; ch_enable = 24'h000001; set_row_const(25'h1FFFFFF);
      end else if (i == 5 || i == 9) begin
        sample_strobe = 1'b0; overrun_clr = (i == 5);
        $display("overrun at word %0d = %b", i, overrun);
        n_checks++;
        if (overrun !== 1'b1) begin
          n_fails++; $display("FAIL ovr_set_w%0d: got %b want 1", i, overrun);
        end
      end else if (i == 6) begin
        overrun_clr = 1'b0;
        n_checks++;
        if (overrun !== 1'b0) begin
          n_fails++; $display("FAIL ovr_clear: got %b want 0", overrun);
        end
      end else if (i == 8) begin
        sample_strobe = 1'b1; overrun_clr = 1'b1;
      end
      tick();
    end
    exp_frames++;
    n_checks++;
    if (bus.out_valid !== 1'b0 || frame_cnt !== exp_frames || overrun !== 1'b1) begin
      n_fails++; $display("FAIL ovr_end: valid=%b frame=%0d overrun=%b want 0 %0d 1", bus.out_valid, frame_cnt, overrun, exp_frames);
    end
    overrun_clr = 1'b1;
    tick();
    overrun_clr = 1'b0;
  endtask

  task automatic test_strobe_on_final();
    set_row_inc(); ch_enable = 24'h000006; bus.out_ready = 1'b1; sample_strobe = 1'b1;
    tick();
    sample_strobe = 1'b0;
    n_checks++;
    if (bus.out_ch !== 5'd1 || bus.out_data !== 25'd2 || bus.out_last !== 1'b0) begin
      n_fails++; $display("FAIL fin_first: ch=%0d data=%h last=%b want 1 2 0", bus.out_ch, bus.out_data, bus.out_last);
    end
    tick();
    n_checks++;
    if (bus.out_ch !== 5'd2 || bus.out_data !== 25'd3 || bus.out_last !== 1'b1) begin
      n_fails++; $display("FAIL fin_last: ch=%0d data=%h last=%b want 2 3 1", bus.out_ch, bus.out_data, bus.out_last);
    end
    set_row_const('0); row_data[3*WORD_W +: WORD_W] = 25'h1ABCDEF;
    ch_enable = 24'h000008; sample_strobe = 1'b1;
    tick();
    sample_strobe = 1'b0;
    exp_frames++;
    $display("word ch=%0d data=%h last=%b frame=%0d", bus.out_ch, bus.out_data, bus.out_last, frame_cnt);
    n_checks++;
    if (bus.out_valid !== 1'b1 || bus.out_ch !== 5'd3 || bus.out_data !== 25'h1ABCDEF || bus.out_last !== 1'b1) begin
      n_fails++; $display("FAIL fin_new_word: valid=%b ch=%0d data=%h last=%b want 1 3 1abcdef 1",
                          bus.out_valid, bus.out_ch, bus.out_data, bus.out_last);
    end
    n_checks++;
    if (overrun !== 1'b0 || frame_cnt !== exp_frames) begin
      n_fails++; $display("FAIL fin_counts: overrun=%b frame=%0d want 0 %0d", overrun, frame_cnt, exp_frames);
    end
    ch_enable = 24'h000000; sample_strobe = 1'b1;
    tick();
    sample_strobe = 1'b0;
    exp_frames = exp_frames + 16'd2;
    n_checks++;
    if (bus.out_valid !== 1'b0 || busy !== 1'b0 || overrun !== 1'b0 || frame_cnt !== exp_frames) begin
      n_fails++; $display("FAIL fin_empty: valid=%b busy=%b overrun=%b frame=%0d want 0 0 0 %0d",
                          bus.out_valid, busy, overrun, frame_cnt, exp_frames);
    end
  endtask

  task automatic test_async_reset();
    set_row_inc(); ch_enable = '1; bus.out_ready = 1'b1; sample_strobe = 1'b1;
    tick();
    sample_strobe = 1'b0;
    repeat (3) tick();
    #2 reset = 1'b1;
    #1;
    $display("async reset mid-frame");
    n_checks++;
    if ({bus.out_valid, bus.out_last, busy, overrun} !== 4'b0000 || bus.out_data !== '0
        || bus.out_ch !== '0 || frame_cnt !== 16'd0) begin
      n_fails++; $display("FAIL async_reset: valid=%b last=%b busy=%b ovr=%b data=%h ch=%0d frame=%0d want all 0",
                          bus.out_valid, bus.out_last, busy, overrun, bus.out_data, bus.out_ch, frame_cnt);
    end
    tick();
    reset = 1'b0;
    exp_frames = '0;
    tick();
    ch_enable = 24'h000010; sample_strobe = 1'b1;
    tick();
    sample_strobe = 1'b0;
    n_checks++;
    if (bus.out_valid !== 1'b1 || bus.out_ch !== 5'd4 || bus.out_data !== 25'd5 || bus.out_last !== 1'b1) begin
      n_fails++; $display("FAIL post_reset_word: valid=%b ch=%0d data=%h last=%b want 1 4 5 1",
                          bus.out_valid, bus.out_ch, bus.out_data, bus.out_last);
    end
    tick();
    exp_frames++;
    n_checks++;
    if (bus.out_valid !== 1'b0 || frame_cnt !== exp_frames) begin
      n_fails++; $display("FAIL post_reset_frame: valid=%b frame=%0d want 0 %0d", bus.out_valid, frame_cnt, exp_frames);
    end
  endtask

  initial begin
    test_reset();
    test_all_channels();
    test_sparse_ready_toggle();
    test_empty_mask();
    test_overrun();
    test_strobe_on_final();
    test_async_reset();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fails);
    $finish;
  end
endmodule
